// File: rtl/bomberman_pkg.sv
// Shared types and constants for the bomberman bomb datapath.
package bomberman_pkg;

  localparam int COORD_W    = 10;
  localparam int TILE_SHIFT = 4;
  // Fuse field is sized for fuses of up to 255 frame ticks.
  localparam int FUSE_W     = 8;

  typedef struct packed {
    logic               valid;
    logic               pending;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [FUSE_W-1:0]  fuse;
  } bomb_slot_t;

  typedef enum logic {
    ISS_IDLE  = 1'b0,
    ISS_ISSUE = 1'b1
  } issue_state_e;

endpackage

// File: rtl/bomb_slot_pick.sv
// Lowest-set-bit priority encoder: returns whether any request bit is set and its index.
module bomb_slot_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bomb_scheduler.sv
// Bomb slot owner: placement, per-frame fuse countdown and serialised explosion writes.
// Optional macro CHAIN_REACTION_EN: an exploding bomb detonates live bombs in its blast cross.
module bomb_scheduler #(
  parameter int MAX_BOMBS   = 4,
  parameter int FUSE_TICKS  = 120,
  parameter int TILE_SHIFT  = bomberman_pkg::TILE_SHIFT,
  parameter int BLAST_RANGE = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 place_req,
  input  logic [9:0]           b_x,
  input  logic [9:0]           b_y,
  output logic                 place_ack,
  output logic                 place_nack,
  output logic                 exp_valid,
  input  logic                 exp_ready,
  output logic [9:0]           exp_x,
  output logic [9:0]           exp_y,
  output logic [MAX_BOMBS-1:0] active_mask,
  output logic [3:0]           bomb_count,
  input  logic [2:0]           rd_idx,
  output logic [9:0]           rd_x,
  output logic [9:0]           rd_y,
  output logic                 rd_live,
  output logic                 dbg_issue_state
);
  import bomberman_pkg::*;

  localparam int IDX_W = (MAX_BOMBS > 1) ? $clog2(MAX_BOMBS) : 1;

  if (MAX_BOMBS < 1 || MAX_BOMBS > 8 || FUSE_TICKS < 1 ||
      FUSE_TICKS >= (1 << FUSE_W) || BLAST_RANGE < 0) begin : g_bad_params
    $error("bomb_scheduler: unsupported parameter set");
  end

  bomb_slot_t slot_q [MAX_BOMBS];
  bomb_slot_t slot_d [MAX_BOMBS];

  issue_state_e         state_q, state_d;
  logic                 exp_valid_q, exp_valid_d;
  logic [9:0]           exp_x_q, exp_x_d, exp_y_q, exp_y_d;
  logic [IDX_W-1:0]     sel_q, sel_d;
  logic                 ack_q, ack_d, nack_q, nack_d;
  logic [MAX_BOMBS-1:0] mask_q, mask_d;
  logic [3:0]           count_q, count_d;
  logic [9:0]           rd_x_q, rd_x_d, rd_y_q, rd_y_d;
  logic                 rd_live_q, rd_live_d;

  logic [MAX_BOMBS-1:0] free_req, pend_req;
  logic                 free_found, pend_found, handshake, dup;
  logic [IDX_W-1:0]     free_idx, pend_idx;
  logic [9:0]           tile_x, tile_y;

  always_comb begin
    for (int i = 0; i < MAX_BOMBS; i++) begin
      free_req[i] = ~slot_q[i].valid;
      pend_req[i] = slot_q[i].valid & slot_q[i].pending;
    end
  end

  bomb_slot_pick #(.N(MAX_BOMBS), .IDX_W(IDX_W)) u_free_pick (
    .req(free_req), .found(free_found), .idx(free_idx)
  );

  bomb_slot_pick #(.N(MAX_BOMBS), .IDX_W(IDX_W)) u_pend_pick (
    .req(pend_req), .found(pend_found), .idx(pend_idx)
  );

`ifdef CHAIN_REACTION_EN
  function automatic logic in_blast(input logic [9:0] x, input logic [9:0] y,
                                    input logic [9:0] ex, input logic [9:0] ey);
    int dx, dy, reach;
    dx    = (x > ex) ? int'(x - ex) : int'(ex - x);
    dy    = (y > ey) ? int'(y - ey) : int'(ey - y);
    reach = BLAST_RANGE << TILE_SHIFT;
    return ((y == ey) && (dx <= reach)) || ((x == ex) && (dy <= reach));
  endfunction
`endif

  // Valid/ready: exp_x/exp_y are held while exp_valid is high; the write completes
  // on the edge where exp_valid && exp_ready, and exp_ready is ignored otherwise.
  always_comb begin
    state_d     = state_q;
    exp_valid_d = exp_valid_q;
    exp_x_d     = exp_x_q;
    exp_y_d     = exp_y_q;
    sel_d       = sel_q;
    handshake   = 1'b0;
    unique case (state_q)
      ISS_IDLE: begin
        if (pend_found) begin
          sel_d       = pend_idx;
          exp_valid_d = 1'b1;
          state_d     = ISS_ISSUE;
          for (int i = 0; i < MAX_BOMBS; i++) begin
            if (IDX_W'(i) == pend_idx) begin
              exp_x_d = slot_q[i].x;
              exp_y_d = slot_q[i].y;
            end
          end
        end
      end
      ISS_ISSUE: begin
        if (exp_ready) begin
          handshake   = 1'b1;
          exp_valid_d = 1'b0;
          state_d     = ISS_IDLE;
        end
      end
      default: state_d = ISS_IDLE;
    endcase
  end

  always_comb begin
    slot_d = slot_q;
    ack_d  = 1'b0;
    nack_d = 1'b0;
    tile_x = (b_x >> TILE_SHIFT) << TILE_SHIFT;
    tile_y = (b_y >> TILE_SHIFT) << TILE_SHIFT;
    dup    = 1'b0;
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (slot_q[i].valid && slot_q[i].x == tile_x && slot_q[i].y == tile_y) dup = 1'b1;
    end

    if (tick) begin
      for (int i = 0; i < MAX_BOMBS; i++) begin
        if (slot_q[i].valid && !slot_q[i].pending) begin
          slot_d[i].fuse = slot_q[i].fuse - FUSE_W'(1);
          if (slot_q[i].fuse == FUSE_W'(1)) slot_d[i].pending = 1'b1;
        end
      end
    end

    if (handshake) begin
`ifdef CHAIN_REACTION_EN
      for (int i = 0; i < MAX_BOMBS; i++) begin
        if (slot_d[i].valid && !slot_d[i].pending &&
            in_blast(slot_d[i].x, slot_d[i].y, exp_x_q, exp_y_q)) begin
          slot_d[i].pending = 1'b1;
          slot_d[i].fuse    = '0;
        end
      end
`endif
      for (int i = 0; i < MAX_BOMBS; i++) begin
        if (IDX_W'(i) == sel_q) begin
          slot_d[i].valid   = 1'b0;
          slot_d[i].pending = 1'b0;
        end
      end
    end

    // Free/duplicate decisions use the registered slots, so a slot freed this cycle waits one cycle.
    if (place_req) begin
      if (dup || !free_found) begin
        nack_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        for (int i = 0; i < MAX_BOMBS; i++) begin
          if (IDX_W'(i) == free_idx) begin
            slot_d[i].valid   = 1'b1;
            slot_d[i].pending = 1'b0;
            slot_d[i].x       = tile_x;
            slot_d[i].y       = tile_y;
            slot_d[i].fuse    = FUSE_W'(FUSE_TICKS);
          end
        end
      end
    end

    mask_d  = '0;
    count_d = '0;
    for (int i = 0; i < MAX_BOMBS; i++) begin
      mask_d[i] = slot_d[i].valid;
      count_d   = count_d + 4'(slot_d[i].valid);
    end

    rd_x_d    = '0;
    rd_y_d    = '0;
    rd_live_d = 1'b0;
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (rd_idx == 3'(i)) begin
        rd_x_d    = slot_q[i].x;
        rd_y_d    = slot_q[i].y;
        rd_live_d = slot_q[i].valid & ~slot_q[i].pending;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_BOMBS; i++) slot_q[i] <= '0;
      state_q     <= ISS_IDLE;
      exp_valid_q <= 1'b0;
      exp_x_q     <= '0;
      exp_y_q     <= '0;
      sel_q       <= '0;
      ack_q       <= 1'b0;
      nack_q      <= 1'b0;
      mask_q      <= '0;
      count_q     <= '0;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      rd_live_q   <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      state_q     <= state_d;
      exp_valid_q <= exp_valid_d;
      exp_x_q     <= exp_x_d;
      exp_y_q     <= exp_y_d;
      sel_q       <= sel_d;
      ack_q       <= ack_d;
      nack_q      <= nack_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      rd_x_q      <= rd_x_d;
      rd_y_q      <= rd_y_d;
      rd_live_q   <= rd_live_d;
    end
  end

  assign place_ack       = ack_q;
  assign place_nack      = nack_q;
  assign exp_valid       = exp_valid_q;
  assign exp_x           = exp_x_q;
  assign exp_y           = exp_y_q;
  assign active_mask     = mask_q;
  assign bomb_count      = count_q;
  assign rd_x            = rd_x_q;
  assign rd_y            = rd_y_q;
  assign rd_live         = rd_live_q;
  assign dbg_issue_state = state_q;

endmodule
